// File: rtl/slave_ooo_if.sv
// Slave-port bus of the out-of-order crossbar.
//
// Handshake: a request transfers on a rising clock edge where req and ack
// are both high; the master holds req/addr/cmd/reqtid/wdata stable until
// then. Responses have no backpressure: resp is a one-cycle pulse carrying
// resptid/rdata, and resptid/rdata read as zero whenever resp is low.
//
// Signals:
//   req     master->slave  request valid
//   addr    master->slave  byte address
//   cmd     master->slave  1 = write, 0 = read
//   reqtid  master->slave  request transaction id
//   wdata   master->slave  write data
//   ack     slave->master  request accepted this cycle
//   resptid slave->master  response transaction id
//   rdata   slave->master  read response data
//   resp    slave->master  read response valid
interface slave_ooo_if #(
  parameter int TID_W = 2
);
  logic             req;
  logic [31:0]      addr;
  logic             cmd;
  logic [TID_W-1:0] reqtid;
  logic [31:0]      wdata;
  logic             ack;
  logic [TID_W-1:0] resptid;
  logic [31:0]      rdata;
  logic             resp;

  modport master (
    output req, addr, cmd, reqtid, wdata,
    input  ack, resptid, rdata, resp
  );

  modport slave (
    input  req, addr, cmd, reqtid, wdata,
    output ack, resptid, rdata, resp
  );
endinterface

// File: rtl/slave_ooo_responder.sv
// Slave-side endpoint for the out-of-order crossbar slave port.
// Holds a word-addressed memory and a table of up to DEPTH outstanding
// tagged reads, returning read data out of order with fixed or
// pseudo-random latency.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   bus        slave modport of slave_ooo_if (request/response bus)
//   dbg_state  per-entry state, entry i in bits [2*i+1:2*i]
//              (0 = FREE, 1 = WAIT, 2 = READY)
module slave_ooo_responder #(
  parameter int          MEMSIZE32 = 1024,
  parameter int          TID_W     = 2,
  parameter int          DEPTH     = 4,
  parameter int          MIN_LAT   = 1,
  parameter int          RAND_EN   = 1,
  parameter logic [3:0]  LAT_MASK  = 4'd7,
  parameter logic [15:0] RAND_SEED = 16'h0001
) (
  input  logic              clk_i,
  input  logic              rst_i,
  slave_ooo_if.slave        bus,
  output logic [2*DEPTH-1:0] dbg_state
);

  localparam int AW = $clog2(MEMSIZE32);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t           state_q [DEPTH];
  logic [4:0]       cnt_q   [DEPTH];
  logic [TID_W-1:0] tid_q   [DEPTH];
  logic [31:0]      data_q  [DEPTH];

  logic [31:0]      mem [MEMSIZE32];
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_next;

  logic [AW-1:0]    idx;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             tid_hit;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             rd_fire;
  logic             wr_fire;
  logic [4:0]       lat_load;
  logic             unused_addr_bits;

  // Upper address bits are ignored so the memory wraps modulo MEMSIZE32.
  assign idx = bus.addr[AW+1:2];
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  assign lat_load = 5'(MIN_LAT) +
                    ((RAND_EN != 0) ? {1'b0, lfsr_q[3:0] & LAT_MASK} : 5'd0);

  // Descending scan so the lowest index wins both the free-entry search
  // and the response arbitration. An entry being selected for response in
  // this cycle still counts as occupied; it becomes allocatable next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    tid_hit    = 1'b0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (state_q[i] == ST_READY) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
      if (state_q[i] != ST_FREE && tid_q[i] == bus.reqtid) begin
        tid_hit = 1'b1;
      end
    end
  end

  // Reads stall on a full table or on a pending read with the same tid,
  // which keeps responses for a given tid in request order.
  assign bus.ack = ~rst_i & bus.req & (bus.cmd | (free_found & ~tid_hit));
  assign rd_fire = bus.ack & ~bus.cmd;
  assign wr_fire = bus.ack & bus.cmd;

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

  // Memory survives reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[idx] <= bus.wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q      <= RAND_SEED;
      bus.resp    <= 1'b0;
      bus.resptid <= '0;
      bus.rdata   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        cnt_q[i]   <= '0;
        tid_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      lfsr_q      <= lfsr_next;
      bus.resp    <= sel_found;
      bus.resptid <= sel_found ? tid_q[sel_idx] : '0;
      bus.rdata   <= sel_found ? data_q[sel_idx] : '0;
      for (int i = 0; i < DEPTH; i++) begin
        case (state_q[i])
          ST_WAIT: begin
            cnt_q[i] <= cnt_q[i] - 5'd1;
            if (cnt_q[i] == 5'd1) begin
              state_q[i] <= ST_READY;
            end
          end
          ST_READY: begin
            // Unselected READY entries hold with cnt at zero.
            if (sel_found && sel_idx == IW'(i)) begin
              state_q[i] <= ST_FREE;
            end
          end
          default: begin
            // Data is captured at acceptance, so later writes to the same
            // word do not affect this pending read.
            if (rd_fire && free_idx == IW'(i)) begin
              state_q[i] <= (lat_load == 5'd0) ? ST_READY : ST_WAIT;
              cnt_q[i]   <= lat_load;
              tid_q[i]   <= bus.reqtid;
              data_q[i]  <= mem[idx];
            end
          end
        endcase
      end
    end
  end

endmodule
